// File: rtl/adder_monitor_pkg.sv
// Shared types and constants for the adder timing monitor.
// Holds the controller state encoding, mode values and the post-window drain length.
package adder_monitor_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StSample,
      StRun,
      StDrain,
      StDone
   } state_e;

   localparam logic ModeExt  = 1'b0;
   localparam logic ModeRing = 1'b1;

   // Covers the synchroniser plus edge-register latency after the ring is opened.
   localparam int unsigned DrainCycles = 3;

endpackage

// File: rtl/edge_sync_counter.sv
// Synchronises an asynchronous ring output, detects rising edges and counts them
// into a saturating counter with a sticky overflow flag.
module edge_sync_counter #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             sig,
   input  logic             clear,
   input  logic             en,
   output logic [CNT_W-1:0] count,
   output logic             overflow
);

   localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [1:0]       sync_q;
   logic             edge_q;
   logic             rise;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;

   assign rise = sync_q[1] & ~edge_q;

   // Overflow marks an edge lost because the counter was already all-ones.
   always_comb begin
      count_d = count_q;
      ovf_d   = ovf_q;
      if (clear) begin
         count_d = '0;
         ovf_d   = 1'b0;
      end else if (en && rise) begin
         if (&count_q) begin
            ovf_d = 1'b1;
         end else begin
            count_d = count_q + CntOne;
         end
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         edge_q  <= 1'b0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], sig};
         edge_q  <= sync_q[1];
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   assign count    = count_q;
   assign overflow = ovf_q;

endmodule

// File: rtl/adder_timing_monitor.sv
// Measurement controller for instrumented adders: settled-sum capture or
// ring-oscillator edge counting over a programmable gate window.
module adder_timing_monitor
   import adder_monitor_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned CNT_W  = 32,
   parameter int unsigned GATE_W = 16,
   parameter int unsigned SETTLE = 2
) (
   input  logic                     wb_clk_i,
   input  logic                     wb_rst_n,
   input  logic                     start,
   output logic                     start_ready,
   input  logic                     mode,
   input  logic [WIDTH-1:0]         a_in,
   input  logic [WIDTH-1:0]         b_in,
   input  logic [$clog2(WIDTH)-1:0] bit_sel,
   input  logic [GATE_W-1:0]        gate_cycles,
   input  logic                     abort,
   output logic                     result_valid,
   input  logic                     result_ack,
   output logic [CNT_W-1:0]         result_count,
   output logic                     result_overflow,
   output logic [WIDTH-1:0]         result_sum,
   output logic                     result_carry,
   output logic [WIDTH-1:0]         a_input,
   output logic [WIDTH-1:0]         b_input,
   output logic [WIDTH-1:0]         ext_bit_b,
   output logic [WIDTH-1:0]         ring_bit_b,
   output logic                     ring_en,
   input  logic                     chain_out,
   input  logic [WIDTH-1:0]         sum_in,
   input  logic                     carry_in
);

   localparam int unsigned SET_W = $clog2(SETTLE + 1) + 1;
   localparam logic [SET_W-1:0]  SettleInit = SET_W'(SETTLE - 1);
   localparam logic [SET_W-1:0]  SettleOne  = {{(SET_W-1){1'b0}}, 1'b1};
   localparam logic [GATE_W-1:0] GateOne    = {{(GATE_W-1){1'b0}}, 1'b1};
   localparam logic [GATE_W-1:0] DrainInit  = GATE_W'(DrainCycles - 1);
   localparam logic [WIDTH-1:0]  BitOne     = {{(WIDTH-1){1'b0}}, 1'b1};

   state_e            state_q, state_d;
   logic [SET_W-1:0]  settle_q, settle_d;
   logic [GATE_W-1:0] timer_q, timer_d;
   logic [GATE_W-1:0] gate_q;
   logic              mode_q;
   logic [WIDTH-1:0]  a_q, b_q, ext_q, ring_q, sum_q;
   logic              carry_q;
   logic              ring_en_q;
   logic              accept, leave;
   logic              cnt_clear, cnt_en;
   logic [WIDTH-1:0]  sel_onehot;

   assign start_ready = (state_q == StIdle);
   assign accept      = start && start_ready;
   assign leave       = (state_q != StIdle) && (state_d == StIdle);
   assign sel_onehot  = BitOne << bit_sel;

   // timer_q counts down the RUN window, then is reused for the DRAIN tail.
   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      timer_d  = timer_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d  = StLoad;
               settle_d = SettleInit;
            end
         end
         StLoad: begin
            if (settle_q == '0) begin
               if (mode_q == ModeExt) begin
                  state_d = StSample;
               end else if (gate_q == '0) begin
                  state_d = StDone;
               end else begin
                  state_d = StRun;
                  timer_d = gate_q - GateOne;
               end
            end else begin
               settle_d = settle_q - SettleOne;
            end
         end
         StSample: state_d = StDone;
         StRun: begin
            if (timer_q == '0) begin
               state_d = StDrain;
               timer_d = DrainInit;
            end else begin
               timer_d = timer_q - GateOne;
            end
         end
         StDrain: begin
            if (timer_q == '0) begin
               state_d = StDone;
            end else begin
               timer_d = timer_q - GateOne;
            end
         end
         StDone: begin
            if (result_ack) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (abort && (state_q != StIdle)) state_d = StIdle;
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state_q   <= StIdle;
         settle_q  <= '0;
         timer_q   <= '0;
         gate_q    <= '0;
         mode_q    <= ModeExt;
         a_q       <= '0;
         b_q       <= '0;
         ext_q     <= '0;
         ring_q    <= '0;
         sum_q     <= '0;
         carry_q   <= 1'b0;
         ring_en_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         settle_q  <= settle_d;
         timer_q   <= timer_d;
         // Registered from next state so the ring enable is glitch-free and RUN-only.
         ring_en_q <= (state_d == StRun);
         if (accept) begin
            mode_q <= mode;
            gate_q <= gate_cycles;
            a_q    <= a_in;
            b_q    <= b_in;
            ext_q  <= (mode == ModeExt)  ? sel_onehot : '0;
            ring_q <= (mode == ModeRing) ? sel_onehot : '0;
         end else if (leave) begin
            ext_q  <= '0;
            ring_q <= '0;
         end
         if ((state_q == StSample) && (state_d == StDone)) begin
            sum_q   <= sum_in;
            carry_q <= carry_in;
         end
      end
   end

   assign cnt_clear = (state_q == StLoad);
   assign cnt_en    = (state_q == StRun) || (state_q == StDrain);

   edge_sync_counter #(
      .CNT_W(CNT_W)
   ) u_edge_cnt (
      .clock    (wb_clk_i),
      .rst_n    (wb_rst_n),
      .sig      (chain_out),
      .clear    (cnt_clear),
      .en       (cnt_en),
      .count    (result_count),
      .overflow (result_overflow)
   );

   assign result_valid = (state_q == StDone);
   assign result_sum   = sum_q;
   assign result_carry = carry_q;
   assign a_input      = a_q;
   assign b_input      = b_q;
   assign ext_bit_b    = ext_q;
   assign ring_bit_b   = ring_q;
   assign ring_en      = ring_en_q;

endmodule

// File: tb/tb_adder_timing_monitor.sv
// Directed plus randomized bench for adder_timing_monitor; a 32-bit and a 4-bit
// counter instance run in lockstep against a rule-level model of the ring.
module tb_adder_timing_monitor;

   localparam int SETTLE = 2;
   localparam int SMALL_MAX = 15;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_n = 1'b1;
   logic        start = 1'b0, mode = 1'b0, abort = 1'b0, result_ack = 1'b0;
   logic [31:0] a_in = '0, b_in = '0;
   logic [4:0]  bit_sel = '0;
   logic [15:0] gate_cycles = '0;

   logic        start_ready, result_valid, result_overflow, result_carry, ring_en;
   logic        chain_out, carry_in;
   logic [31:0] result_count, result_sum, a_input, b_input, ext_bit_b, ring_bit_b, sum_in;

   logic        s_start_ready, s_result_valid, s_result_overflow, s_result_carry, s_ring_en;
   logic        s_chain_out, s_carry_in;
   logic [3:0]  s_result_count;
   logic [31:0] s_result_sum, s_a_input, s_b_input, s_ext_bit_b, s_ring_bit_b, s_sum_in;

   int n_tests = 0;
   int n_fail  = 0;
   int period  = 4;

   always #5 wb_clk_i = ~wb_clk_i;

   // Ideal adders under test.
   assign {carry_in, sum_in}     = {1'b0, a_input} + {1'b0, b_input};
   assign {s_carry_in, s_sum_in} = {1'b0, s_a_input} + {1'b0, s_b_input};

   adder_timing_monitor #(.WIDTH(32), .CNT_W(32), .GATE_W(16), .SETTLE(SETTLE)) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_n(wb_rst_n), .start(start), .start_ready(start_ready),
      .mode(mode), .a_in(a_in), .b_in(b_in), .bit_sel(bit_sel), .gate_cycles(gate_cycles),
      .abort(abort), .result_valid(result_valid), .result_ack(result_ack),
      .result_count(result_count), .result_overflow(result_overflow),
      .result_sum(result_sum), .result_carry(result_carry), .a_input(a_input),
      .b_input(b_input), .ext_bit_b(ext_bit_b), .ring_bit_b(ring_bit_b), .ring_en(ring_en),
      .chain_out(chain_out), .sum_in(sum_in), .carry_in(carry_in)
   );

   adder_timing_monitor #(.WIDTH(32), .CNT_W(4), .GATE_W(16), .SETTLE(SETTLE)) dut_s (
      .wb_clk_i(wb_clk_i), .wb_rst_n(wb_rst_n), .start(start), .start_ready(s_start_ready),
      .mode(mode), .a_in(a_in), .b_in(b_in), .bit_sel(bit_sel), .gate_cycles(gate_cycles),
      .abort(abort), .result_valid(s_result_valid), .result_ack(result_ack),
      .result_count(s_result_count), .result_overflow(s_result_overflow),
      .result_sum(s_result_sum), .result_carry(s_result_carry), .a_input(s_a_input),
      .b_input(s_b_input), .ext_bit_b(s_ext_bit_b), .ring_bit_b(s_ring_bit_b),
      .ring_en(s_ring_en), .chain_out(s_chain_out), .sum_in(s_sum_in), .carry_in(s_carry_in)
   );

   // Ring oscillator model: first rise one cycle after ring_en, square wave of `period`.
   initial begin : ring_gen
      int ph, sph;
      ph = 0;
      sph = 0;
      chain_out = 1'b0;
      s_chain_out = 1'b0;
      forever begin
         @(posedge wb_clk_i);
         #2;
         if (ring_en) begin
            chain_out = ((ph % period) >= 1) && ((ph % period) <= period / 2);
            ph++;
         end else begin
            chain_out = 1'b0;
            ph = 0;
         end
         if (s_ring_en) begin
            s_chain_out = ((sph % period) >= 1) && ((sph % period) <= period / 2);
            sph++;
         end else begin
            s_chain_out = 1'b0;
            sph = 0;
         end
      end
   end

   // Rises happen at RUN offsets 1, 1+p, 1+2p, ... strictly before the window closes.
   function automatic int rises(input int g, input int p);
      int n = 0;
      for (int q = 1; q < g; q++) if ((q % p) == 1) n++;
      return n;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ring(output int ok);
      int k = 0;
      while (!ring_en && k < 50) begin
         @(negedge wb_clk_i);
         k++;
      end
      ok = ring_en ? 1 : 0;
   endtask

   task automatic transact(input logic m, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] sel, input int g, input int p,
                           input logic ack_with_start);
      int j, ren, r;
      logic [32:0] sum_exp;
      period = p;
      @(negedge wb_clk_i);
      check("ready_before_start", start_ready, 1);
      mode = m; a_in = a; b_in = b; bit_sel = sel; gate_cycles = 16'(g); start = 1'b1;
      @(negedge wb_clk_i);
      start = 1'b0; a_in = ~a; b_in = ~b;
      j = 0;
      ren = 0;
      while (!result_valid && j < 400) begin
         if (ring_en) ren++;
         @(negedge wb_clk_i);
         j++;
      end
      check("valid_seen", result_valid, 1);
      check("valid_small", s_result_valid, 1);
      if (m == 1'b0 || g != 0) check("latency", j, (m ? SETTLE + g + 3 : SETTLE + 1));
      check("ring_en_cycles", ren, (m ? g : 0));
      check("a_input", a_input, a);
      check("b_input", b_input, b);
      check("ext_mask", ext_bit_b, (m ? 64'd0 : (64'd1 << sel)));
      check("ring_mask", ring_bit_b, (m ? (64'd1 << sel) : 64'd0));
      sum_exp = {1'b0, a} + {1'b0, b};
      if (m == 1'b0) begin
         check("sum", result_sum, sum_exp[31:0]);
         check("carry", result_carry, sum_exp[32]);
      end else begin
         r = rises(g, p);
         check("count", result_count, r);
         check("overflow", result_overflow, 0);
         check("count_small", s_result_count, (r > SMALL_MAX ? SMALL_MAX : r));
         check("overflow_small", s_result_overflow, (r > SMALL_MAX ? 1 : 0));
      end
      @(negedge wb_clk_i);
      check("valid_held", result_valid, 1);
      result_ack = 1'b1;
      if (ack_with_start) start = 1'b1;
      @(negedge wb_clk_i);
      result_ack = 1'b0;
      start = 1'b0;
      check("valid_after_ack", result_valid, 0);
      check("masks_cleared", {ext_bit_b, ring_bit_b}, 0);
      @(negedge wb_clk_i);
      check("idle_after_ack", start_ready, 1);
   endtask

   initial begin : main
      int ok, seen;
      #1 wb_rst_n = 1'b0;
      @(negedge wb_clk_i);
      @(negedge wb_clk_i);
      check("rst_ready", start_ready, 1);
      check("rst_valid", result_valid, 0);
      check("rst_outs", {a_input, b_input, ext_bit_b, ring_bit_b, result_sum}, 0);
      check("rst_count", {result_count, result_overflow, result_carry, ring_en}, 0);
      wb_rst_n = 1'b1;

      transact(1'b0, 32'hFFFF_FFFF, 32'h1, 5'd5, 0, 4, 1'b0);
      transact(1'b1, 32'h1234_5678, 32'h0F0F_0F0F, 5'd9, 40, 4, 1'b0);
      transact(1'b1, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 5'd31, 80, 4, 1'b0);
      transact(1'b1, 32'h0000_0003, 32'h0000_0004, 5'd0, 0, 4, 1'b1);

      // Abort in the fifth RUN cycle.
      period = 4;
      @(negedge wb_clk_i);
      mode = 1'b1; gate_cycles = 16'd40; bit_sel = 5'd3; start = 1'b1;
      @(negedge wb_clk_i);
      start = 1'b0;
      wait_ring(ok);
      check("abort_ring_started", ok, 1);
      repeat (4) @(negedge wb_clk_i);
      check("abort_ring_cycle5", ring_en, 1);
      abort = 1'b1;
      @(negedge wb_clk_i);
      abort = 1'b0;
      check("abort_idle", start_ready, 1);
      check("abort_ring_off", ring_en, 0);
      check("abort_masks", {ext_bit_b, ring_bit_b}, 0);
      seen = 0;
      repeat (60) begin
         @(negedge wb_clk_i);
         if (result_valid) seen++;
      end
      check("abort_no_result", seen, 0);
      transact(1'b0, 32'h8000_0000, 32'h8000_0001, 5'd17, 0, 4, 1'b0);

      // Start pulsed mid-RUN must be ignored.
      period = 4;
      @(negedge wb_clk_i);
      mode = 1'b1; gate_cycles = 16'd30; a_in = 32'hCAFE_0001; b_in = 32'h2; start = 1'b1;
      @(negedge wb_clk_i);
      start = 1'b0;
      wait_ring(ok);
      repeat (2) @(negedge wb_clk_i);
      check("busy_not_ready", start_ready, 0);
      a_in = 32'h0BAD_0BAD; start = 1'b1;
      @(negedge wb_clk_i);
      start = 1'b0;
      seen = 0;
      while (!result_valid && seen < 100) begin
         @(negedge wb_clk_i);
         seen++;
      end
      check("busy_result", result_valid, 1);
      check("busy_count", result_count, rises(30, 4));
      check("busy_a_kept", a_input, 32'hCAFE_0001);
      result_ack = 1'b1;
      @(negedge wb_clk_i);
      result_ack = 1'b0;
      seen = 0;
      repeat (60) begin
         @(negedge wb_clk_i);
         if (result_valid || !start_ready) seen++;
      end
      check("busy_single_result", seen, 0);

      for (int i = 0; i < 8; i++) begin
         transact(1'($urandom_range(0, 1)), $urandom(), $urandom(),
                  5'($urandom_range(0, 31)), int'($urandom_range(0, 60)),
                  2 * int'($urandom_range(1, 4)), 1'b0);
      end

      // Reset mid-RUN drops ring_en without waiting for a clock edge.
      period = 4;
      @(negedge wb_clk_i);
      mode = 1'b1; gate_cycles = 16'd40; start = 1'b1;
      @(negedge wb_clk_i);
      start = 1'b0;
      wait_ring(ok);
      repeat (3) @(negedge wb_clk_i);
      #2 wb_rst_n = 1'b0;
      #1;
      check("rst_run_ring", ring_en, 0);
      check("rst_run_ring_small", s_ring_en, 0);
      check("rst_run_ready", start_ready, 1);
      check("rst_run_outs", {ext_bit_b, ring_bit_b, result_count}, 0);
      @(negedge wb_clk_i);
      wb_rst_n = 1'b1;
      transact(1'b1, 32'h1, 32'h1, 5'd2, 12, 2, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
